// File: rtl/ro_puf_pkg.sv
// Shared FSM state encoding and default parameter constants for the RO PUF engine.
package ro_puf_pkg;

  localparam int unsigned N_BITS_DEF     = 8;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned WIN_W_DEF      = 16;
  localparam int unsigned VOTES_DEF      = 3;
  localparam int unsigned SETTLE_CYC_DEF = 4;

  // Vote accumulators and vote index are sized for VOTES up to 15
  localparam int unsigned VOTE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one free-running oscillator, detects its rising edges and counts
// them into a saturating counter that can be cleared.
module ro_edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             osc,
  output logic [CNT_W-1:0] count
);

  // sync[1:0] is the two-flop synchroniser, sync[2] the previous synchronised value
  logic [2:0] sync;
  logic       rise;

  assign rise = sync[1] & ~sync[2];

  // Synchroniser and edge-detect history run continuously
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 3'b000;
    end else begin
      sync <= {sync[1:0], osc};
    end
  end

  // Saturating edge counter; clear wins over counting
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && rise && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ro_puf_engine.sv
// Ring-oscillator PUF engine: settles the oscillator pairs, measures edge counts
// over a window, majority-votes A-faster-than-B over VOTES runs and masks the
// result with the latched challenge.
module ro_puf_engine
  import ro_puf_pkg::*;
#(
  parameter int unsigned N_BITS     = N_BITS_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned WIN_W      = WIN_W_DEF,
  parameter int unsigned VOTES      = VOTES_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              start,
  input  logic [N_BITS-1:0] challenge,
  input  logic [WIN_W-1:0]  window,
  input  logic [N_BITS-1:0] ro_a,
  input  logic [N_BITS-1:0] ro_b,
  output logic              ro_en,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] response,
  output logic [N_BITS-1:0] tie
);

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t                        state;
  logic [N_BITS-1:0]             chal_q;
  logic [WIN_W-1:0]              win_q;
  logic [WIN_W-1:0]              meas_cnt;
  logic [SET_W-1:0]              set_cnt;
  logic [VOTE_W-1:0]             vote_idx;
  logic [N_BITS-1:0][VOTE_W-1:0] votes;
  logic [N_BITS-1:0][VOTE_W-1:0] votes_nxt;
  logic [N_BITS-1:0]             tie_acc;
  logic [N_BITS-1:0]             tie_nxt;
  logic [N_BITS-1:0]             resp_nxt;
  logic [N_BITS-1:0][CNT_W-1:0]  cnt_a;
  logic [N_BITS-1:0][CNT_W-1:0]  cnt_b;
  logic                          cnt_clr;
  logic                          cnt_en;

  // Counters only run in MEASURE, hold through COMPARE, and are zero otherwise
  assign cnt_en  = (state == ST_MEASURE);
  assign cnt_clr = (state != ST_MEASURE) && (state != ST_COMPARE);

  for (genvar g = 0; g < int'(N_BITS); g++) begin : g_pair
    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .osc   (ro_a[g]),
      .count (cnt_a[g])
    );
    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .osc   (ro_b[g]),
      .count (cnt_b[g])
    );
  end

  // Vote/tie accumulators after the current comparison, and the response they imply
  always_comb begin
    votes_nxt = votes;
    tie_nxt   = tie_acc;
    resp_nxt  = '0;
    for (int unsigned i = 0; i < N_BITS; i++) begin
      if (cnt_a[i] > cnt_b[i]) begin
        votes_nxt[i] = votes[i] + VOTE_W'(1);
      end else if (cnt_a[i] == cnt_b[i]) begin
        tie_nxt[i] = 1'b1;
      end
      resp_nxt[i] = (votes_nxt[i] > VOTE_W'(VOTES / 2)) ^ chal_q[i];
    end
  end

  // Sequencing FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      chal_q   <= '0;
      win_q    <= '0;
      meas_cnt <= '0;
      set_cnt  <= '0;
      vote_idx <= '0;
      votes    <= '0;
      tie_acc  <= '0;
      ro_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      response <= '0;
      tie      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && ena) begin
            chal_q   <= challenge;
            win_q    <= (window == '0) ? WIN_W'(1) : window;
            votes    <= '0;
            tie_acc  <= '0;
            vote_idx <= '0;
            set_cnt  <= '0;
            ro_en    <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (set_cnt == SET_W'(SETTLE_CYC - 1)) begin
            set_cnt  <= '0;
            meas_cnt <= WIN_W'(1);
            state    <= ST_MEASURE;
          end else begin
            set_cnt <= set_cnt + SET_W'(1);
          end
        end
        ST_MEASURE: begin
          if (meas_cnt == win_q) begin
            state <= ST_COMPARE;
          end else begin
            meas_cnt <= meas_cnt + WIN_W'(1);
          end
        end
        ST_COMPARE: begin
          votes    <= votes_nxt;
          tie_acc  <= tie_nxt;
          vote_idx <= vote_idx + VOTE_W'(1);
          if (vote_idx == VOTE_W'(VOTES - 1)) begin
            response <= resp_nxt;
            tie      <= tie_nxt;
            done     <= 1'b1;
            ro_en    <= 1'b0;
            state    <= ST_DONE;
          end else begin
            state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          ro_en <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_engine.sv
// Directed self-checking bench for ro_puf_engine (default instance plus a
// CNT_W=4 instance for saturation).
module tb_ro_puf_engine;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       start;
  logic [7:0] challenge;
  logic [15:0] window;
  logic [7:0] ro_a;
  logic [7:0] ro_b;

  logic       ro_en, busy, done;
  logic [7:0] response, tie;
  logic       s_ro_en, s_busy, s_done;
  logic [7:0] s_response, s_tie;

  // Oscillator sources: half periods in time units (clk period is 10), 0 = held low
  int         half_a;
  int         half_b;
  logic       osc_a;
  logic       osc_b;
  logic [7:0] mask_a;
  logic [7:0] mask_b;
  logic       same_src;

  int checks;
  int failures;
  int done_pulses;

  assign ro_a = mask_a & {8{osc_a}};
  assign ro_b = mask_b & {8{same_src ? osc_a : osc_b}};

  ro_puf_engine dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .start     (start),
    .challenge (challenge),
    .window    (window),
    .ro_a      (ro_a),
    .ro_b      (ro_b),
    .ro_en     (ro_en),
    .busy      (busy),
    .done      (done),
    .response  (response),
    .tie       (tie)
  );

  ro_puf_engine #(.CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .start     (start),
    .challenge (challenge),
    .window    (window),
    .ro_a      (ro_a),
    .ro_b      (ro_b),
    .ro_en     (s_ro_en),
    .busy      (s_busy),
    .done      (s_done),
    .response  (s_response),
    .tie       (s_tie)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oscillator A: toggles land on multiples of 10, i.e. on falling clk edges
  initial begin
    osc_a = 1'b0;
    forever begin
      if (half_a == 0) begin
        osc_a = 1'b0;
        #10;
      end else begin
        #(half_a);
        osc_a = ~osc_a;
      end
    end
  end

  // Oscillator B
  initial begin
    osc_b = 1'b0;
    forever begin
      if (half_b == 0) begin
        osc_b = 1'b0;
        #10;
      end else begin
        #(half_b);
        osc_b = ~osc_b;
      end
    end
  end

  // Count cycles with done high on the default instance
  always @(posedge clk) begin
    if (done) done_pulses <= done_pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present start for one cycle (cycle 0) and return the cycle in which done is seen
  task automatic run(input logic [7:0] chal, input logic [15:0] win, input int budget,
                     output int lat);
    start     = 1'b1;
    challenge = chal;
    window    = win;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < budget) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int p0;
  int cyc;

  initial begin
    checks      = 0;
    failures    = 0;
    done_pulses = 0;
    rst         = 1'b1;
    ena         = 1'b1;
    start       = 1'b0;
    challenge   = 8'h00;
    window      = 16'd0;
    half_a      = 0;
    half_b      = 0;
    mask_a      = 8'h00;
    mask_b      = 8'h00;
    same_src    = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_ro_en", 32'(ro_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_response", 32'(response), 32'h0);
    chk("rst_tie", 32'(tie), 32'h0);
    rst = 1'b0;
    tick();

    // Start ignored while ena is low
    ena   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ena_low_busy", 32'(busy), 32'h0);
    ena = 1'b1;
    tick();

    // Test 1: A period 4, B period 6 on bit 0, W=100 -> 3*(4+100+1)+1 = 316
    mask_a = 8'h01;
    mask_b = 8'h01;
    half_a = 20;
    half_b = 30;
    repeat (10) tick();
    run(8'h00, 16'd100, 400, lat);
    chk("t1_latency", 32'(lat), 32'd316);
    chk("t1_response", 32'(response), 32'h01);
    chk("t1_tie", 32'(tie), 32'hFE);
    chk("t1_done_ro_en", 32'(ro_en), 32'h0);
    chk("t1_done_busy", 32'(busy), 32'h1);
    chk("t1_sat_tie", 32'(s_tie), 32'hFF);
    chk("t1_sat_response", 32'(s_response), 32'h00);
    tick();
    chk("t1_done_pulse_end", 32'(done), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_response_hold", 32'(response), 32'h01);

    // Test 2: identical waveform on both oscillators of every bit, W=30
    same_src = 1'b1;
    mask_a   = 8'hFF;
    mask_b   = 8'hFF;
    repeat (5) tick();
    run(8'hA5, 16'd30, 300, lat);
    chk("t2_latency", 32'(lat), 32'd106);
    chk("t2_response", 32'(response), 32'hA5);
    chk("t2_tie", 32'(tie), 32'hFF);

    // Test 3: A period 2, B period 4, W=200; the 4-bit counters saturate
    same_src = 1'b0;
    half_a   = 10;
    half_b   = 20;
    repeat (5) tick();
    run(8'h3C, 16'd200, 800, lat);
    chk("t3_latency", 32'(lat), 32'd616);
    chk("t3_sat_done", 32'(s_done), 32'h1);
    chk("t3_sat_response", 32'(s_response), 32'h3C);
    chk("t3_sat_tie", 32'(s_tie), 32'hFF);
    chk("t3_response", 32'(response), 32'hC3);
    chk("t3_tie", 32'(tie), 32'h00);
    tick();

    // Test 4: reset during the second MEASURE (cycles 34..57 for W=24)
    mask_a    = 8'h01;
    mask_b    = 8'h01;
    half_a    = 20;
    half_b    = 30;
    repeat (5) tick();
    start     = 1'b1;
    challenge = 8'h00;
    window    = 16'd24;
    tick();
    start = 1'b0;
    p0    = done_pulses;
    chk("t4_cycle1_busy", 32'(busy), 32'h1);
    chk("t4_cycle1_ro_en", 32'(ro_en), 32'h1);
    repeat (39) tick();
    chk("t4_mid_ro_en", 32'(ro_en), 32'h1);
    rst = 1'b1;
    tick();
    chk("t4_abort_ro_en", 32'(ro_en), 32'h0);
    chk("t4_abort_busy", 32'(busy), 32'h0);
    chk("t4_abort_done", 32'(done), 32'h0);
    chk("t4_abort_response", 32'(response), 32'h00);
    rst = 1'b0;
    repeat (100) tick();
    chk("t4_no_done", 32'(done_pulses - p0), 32'd0);
    run(8'h00, 16'd24, 200, lat);
    chk("t4_rerun_latency", 32'(lat), 32'd88);
    chk("t4_rerun_response", 32'(response), 32'h01);
    chk("t4_rerun_tie", 32'(tie), 32'hFE);
    repeat (3) tick();

    // Test 5: start held high and inputs changed mid-run, still high during DONE
    start     = 1'b1;
    challenge = 8'h10;
    window    = 16'd24;
    tick();
    start = 1'b0;
    p0    = done_pulses;
    cyc   = 1;
    repeat (9) begin
      tick();
      cyc++;
    end
    start     = 1'b1;
    challenge = 8'hFF;
    window    = 16'd0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("t5_latency", 32'(cyc), 32'd88);
    chk("t5_response", 32'(response), 32'h11);
    chk("t5_tie", 32'(tie), 32'hFE);
    tick();
    start = 1'b0;
    chk("t5_start_at_done_busy", 32'(busy), 32'h0);
    tick();
    chk("t5_still_idle", 32'(busy), 32'h0);
    chk("t5_single_done", 32'(done_pulses - p0), 32'd1);

    // Test 6: window 0 measures for one cycle -> 3*(4+1+1)+1 = 19
    mask_a = 8'h00;
    mask_b = 8'h00;
    half_a = 0;
    half_b = 0;
    repeat (3) tick();
    run(8'h5A, 16'd0, 100, lat);
    chk("t6_latency", 32'(lat), 32'd19);
    chk("t6_response", 32'(response), 32'h5A);
    chk("t6_tie", 32'(tie), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
